// File: rtl/scanner_pkg.sv
// Shared definitions for the truth-table scanner.
//   state_t              : scan controller states.
//   EXPECTED_A_OR_NOT_B  : golden 2-input table for s = a | ~b (bit i = output for vector i).
//   table_width()        : number of table entries for a given input count.
package scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  // Vectors 0..3 are (a,b) = 00,01,10,11 -> s = 1,0,1,1.
  localparam logic [3:0] EXPECTED_A_OR_NOT_B = 4'b1101;

  function automatic int table_width(input int n_inputs);
    return 1 << n_inputs;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter for the scanner.
//   clk    : rising-edge clock.
//   rst_n  : synchronous active-low reset.
//   load   : clear the count (held while the controller is not settling).
//   expire : count has reached SETTLE_CYCLES-1; the vector has been held long enough.
module settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expire
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign expire = (cnt == LAST);

  // Saturates at LAST so the counter never wraps if the controller lingers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (!expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Clocked stimulus-and-capture stage for a small combinational gate block.
// Walks every input vector in ascending order, holds each for SETTLE_CYCLES,
// samples the gate output, and compares the assembled table with EXPECTED.
//   clk       : rising-edge clock.
//   rst_n     : synchronous active-low reset (priority over start).
//   start     : one-cycle scan request, honoured only in IDLE.
//   vec_out   : vector driven to the gate; bit [N_INPUTS-1] is a, bit 0 is b.
//   s_in      : gate output, sampled in SAMPLE.
//   busy      : scan in progress.
//   done      : one-cycle pulse when the scan result is available.
//   table_out : captured table; bit i = s_in sampled while vec_out == i.
//   match     : table_out == EXPECTED, valid from done until the next start.
module truth_table_scanner
  import scanner_pkg::*;
#(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter logic [table_width(N_INPUTS)-1:0] EXPECTED = EXPECTED_A_OR_NOT_B
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic [N_INPUTS-1:0]               vec_out,
  input  logic                              s_in,
  output logic                              busy,
  output logic                              done,
  output logic [table_width(N_INPUTS)-1:0]  table_out,
  output logic                              match
);

  localparam int TW = table_width(N_INPUTS);
  // One spare bit so the last-index compare can never alias through a wrap.
  localparam int IW = N_INPUTS + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TW - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [N_INPUTS-1:0] vec_d;
  logic [TW-1:0]     table_d;
  logic              busy_d, done_d, match_d;
  logic              timer_load, timer_expire;

  settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .expire (timer_expire)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    vec_d      = vec_out;
    table_d    = table_out;
    busy_d     = busy;
    match_d    = match;
    done_d     = 1'b0;
    // Timer is cleared everywhere except while a vector is settling.
    timer_load = 1'b1;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          vec_d   = '0;
          table_d = '0;
          match_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      SETTLE: begin
        timer_load = 1'b0;
        if (timer_expire) begin
          state_d = SAMPLE;
        end
      end

      SAMPLE: begin
        table_d[idx_q[N_INPUTS-1:0]] = s_in;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IW'(1);
          vec_d   = idx_d[N_INPUTS-1:0];
          state_d = SETTLE;
        end
      end

      DONE: begin
        // The final table bit lands on entry to DONE, so the verdict and the
        // done pulse are registered together on the way out.
        done_d  = 1'b1;
        match_d = (table_out == EXPECTED);
        busy_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      vec_out   <= '0;
      table_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      match     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      vec_out   <= vec_d;
      table_out <= table_d;
      busy      <= busy_d;
      done      <= done_d;
      match     <= match_d;
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a SETTLE_CYCLES=1 instance driven by
// a selectable gate model (a | ~b or a & b) and a SETTLE_CYCLES=3 instance
// driven by the a | ~b model. Inputs change and outputs are sampled on the
// falling edge. Observation index j counts rising edges since the one that
// accepted start (j = 0 is the cycle right after acceptance).
module tb_truth_table_scanner;
  import scanner_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // SETTLE_CYCLES = 1 instance
  logic       rst_n, start, s_in, busy, done, match, faulty;
  logic [1:0] vec_out;
  logic [3:0] table_out;

  // SETTLE_CYCLES = 3 instance
  logic       rst3_n, start3, s_in3, busy3, done3, match3;
  logic [1:0] vec3;
  logic [3:0] table3;

  int n_checks = 0;
  int n_fail   = 0;

  // Gate models: a = vec[1], b = vec[0].
  always_comb s_in  = faulty ? (vec_out[1] & vec_out[0]) : (vec_out[1] | ~vec_out[0]);
  always_comb s_in3 = vec3[1] | ~vec3[0];

  truth_table_scanner #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .s_in(s_in),
    .busy(busy), .done(done), .table_out(table_out), .match(match)
  );

  truth_table_scanner #(.N_INPUTS(2), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .start(start3), .vec_out(vec3), .s_in(s_in3),
    .busy(busy3), .done(done3), .table_out(table3), .match(match3)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full scan on the SETTLE_CYCLES=1 instance. poke[j] re-asserts start
  // during observation j (it must be ignored while busy).
  task automatic scan1(input logic [3:0] exp_tab, input logic exp_match, input logic [11:0] poke);
    int dones;
    dones = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if (done) dones++;
      if (j <= 7) check("vec_seq", vec_out, j / 2);
      if (j <= 8) begin
        check("busy_during_scan", busy, 1);
        check("no_early_done", done, 0);
      end
      if (j == 9) begin
        check("done_cycle9", done, 1);
        check("table_final", table_out, exp_tab);
        check("match_final", match, exp_match);
        check("busy_in_done", busy, 1);
      end
      if (j == 10) begin
        check("done_one_cycle", done, 0);
        check("busy_cleared", busy, 0);
        check("vec_held_last", vec_out, 3);
        check("match_held", match, exp_match);
        check("table_held", table_out, exp_tab);
      end
      start = poke[j];
      @(negedge clk);
    end
    start = 1'b0;
    check("single_done_pulse", dones, 1);
  endtask

  // Bounded search for the done pulse on the SETTLE_CYCLES=1 instance;
  // returns -1 if it never appears.
  task automatic find_done(output int seen);
    seen = -1;
    for (int j = 0; j < 30; j++) begin
      if (done) begin
        seen = j;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int seen;
    int dones;

    rst_n = 1'b0; start = 1'b0; faulty = 1'b0;
    rst3_n = 1'b0; start3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_vec", vec_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_table", table_out, 0);
    check("rst_match", match, 0);
    check("rst3_table", table3, 0);
    rst_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // Golden gate.
    scan1(4'b1101, 1'b1, 12'h000);

    // Faulty gate a & b.
    faulty = 1'b1;
    scan1(4'b1000, 1'b0, 12'h000);
    faulty = 1'b0;

    // Start pulses in cycles 3 and 5 must not restart the scan.
    scan1(4'b1101, 1'b1, 12'b0000_0010_1000);

    // Mid-scan reset in cycle 4.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 4; j++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_vec", vec_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_table", table_out, 0);
    check("midrst_match", match, 0);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("midrst_no_done", dones, 0);
    scan1(4'b1101, 1'b1, 12'h000);

    // Back-to-back scans: start in the idle cycle that shows done.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    find_done(seen);
    check("b2b_first_done", seen, 9);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_vec_restart", vec_out, 0);
    check("b2b_table_clear", table_out, 0);
    check("b2b_match_clear", match, 0);
    check("b2b_busy", busy, 1);
    find_done(seen);
    check("b2b_second_done", seen, 9);
    check("b2b_table", table_out, 4'b1101);
    check("b2b_match", match, 1);
    @(negedge clk);

    // SETTLE_CYCLES = 3: each vector held 4 cycles, done at cycle 17.
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    dones = 0;
    for (int j = 0; j < 20; j++) begin
      if (done3) dones++;
      if (j <= 15) check("s3_vec_seq", vec3, j / 4);
      if (j == 16) check("s3_no_early_done", done3, 0);
      if (j == 17) begin
        check("s3_done_cycle17", done3, 1);
        check("s3_table", table3, 4'b1101);
        check("s3_match", match3, 1);
      end
      @(negedge clk);
    end
    check("s3_single_done", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
